// File: rtl/joy_pkg.sv
// Shared joystick bit-index constants for both players.
package joy_pkg;

  localparam int unsigned JOY_UP    = 0;
  localparam int unsigned JOY_DOWN  = 1;
  localparam int unsigned JOY_LEFT  = 2;
  localparam int unsigned JOY_RIGHT = 3;
  localparam int unsigned JOY_FIRE1 = 4;
  localparam int unsigned JOY_FIRE2 = 5;
  localparam int unsigned JOY_FIRE3 = 6;
  localparam int unsigned JOY_START = 7;
  localparam int unsigned P2_OFFSET = 8;

  localparam int unsigned JOY_BITS  = 16;

endpackage

// File: rtl/joy_debounce_bit.sv
// Single-bit debouncer: tracks a stable level and a count of consecutive
// differing sample ticks; flips the stable level after DEB_COUNT of them.
module joy_debounce_bit #(
  parameter int unsigned DEB_COUNT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic sync_in,
  output logic stable
);

  localparam int unsigned DEB_W = $clog2(DEB_COUNT + 1);

  logic             stable_q, stable_d;
  logic [DEB_W-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (tick) begin
      if (sync_in == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q == DEB_W'(DEB_COUNT - 1)) begin
        stable_d = ~stable_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + DEB_W'(1);
      end
    end
  end

  // Stable level resets to 1: buttons are active-low, so 1 means released.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/joy_conditioner.sv
// Two-player joystick conditioner: synchronise, debounce, press-edge detect.
// Optional autofire on fire1 is built when JOY_AUTOFIRE_EN is defined.
module joy_conditioner
  import joy_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 1024,
  parameter int unsigned DEB_COUNT = 4,
  parameter int unsigned AF_TICKS  = 8
) (
  input  logic                clk,
  input  logic                reset,
`ifdef JOY_AUTOFIRE_EN
  input  logic [1:0]          af_en,
`endif
  input  logic [JOY_BITS-1:0] joy_in,
  output logic [JOY_BITS-1:0] joy_state,
  output logic [JOY_BITS-1:0] joy_press,
  output logic                any_press
);

  localparam int unsigned TICK_W = 16;

  logic [JOY_BITS-1:0] sync1_q, sync1_d;
  logic [JOY_BITS-1:0] sync2_q, sync2_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic                tick_c;
  logic [JOY_BITS-1:0] stable_c;
  logic [JOY_BITS-1:0] deb_c;
  logic [JOY_BITS-1:0] press_c;
  logic [JOY_BITS-1:0] deb_q, deb_d;
  logic [JOY_BITS-1:0] joy_state_q, joy_state_d;
  logic [JOY_BITS-1:0] joy_press_q, joy_press_d;
  logic                any_press_q, any_press_d;

  assign tick_c = (tick_cnt_q == TICK_W'(TICK_DIV - 1));

  always_comb begin
    sync1_d    = joy_in;
    sync2_d    = sync1_q;
    tick_cnt_d = tick_c ? '0 : tick_cnt_q + TICK_W'(1);
  end

  for (genvar i = 0; i < JOY_BITS; i++) begin : g_deb
    joy_debounce_bit #(
      .DEB_COUNT(DEB_COUNT)
    ) u_deb (
      .clk     (clk),
      .reset   (reset),
      .tick    (tick_c),
      .sync_in (sync2_q[i]),
      .stable  (stable_c[i])
    );
  end

  // Press edges come from the debounced level only, never from autofire.
  assign deb_c   = ~stable_c;
  assign press_c = deb_c & ~deb_q;

`ifdef JOY_AUTOFIRE_EN
  localparam int unsigned AF_W = 8;

  logic [1:0]           af_phase_q, af_phase_d;
  logic [1:0][AF_W-1:0] af_cnt_q, af_cnt_d;

  // Phase restarts high on every press and whenever autofire is idle.
  always_comb begin
    af_phase_d  = af_phase_q;
    af_cnt_d    = af_cnt_q;
    joy_state_d = deb_c;
    for (int p = 0; p < 2; p++) begin
      if (!deb_c[4'(p * P2_OFFSET + JOY_FIRE1)] || !af_en[1'(p)] ||
          press_c[4'(p * P2_OFFSET + JOY_FIRE1)]) begin
        af_phase_d[1'(p)] = 1'b1;
        af_cnt_d[1'(p)]   = '0;
      end else if (tick_c) begin
        if (af_cnt_q[1'(p)] == AF_W'(AF_TICKS - 1)) begin
          af_phase_d[1'(p)] = ~af_phase_q[1'(p)];
          af_cnt_d[1'(p)]   = '0;
        end else begin
          af_cnt_d[1'(p)] = af_cnt_q[1'(p)] + AF_W'(1);
        end
      end
      joy_state_d[4'(p * P2_OFFSET + JOY_FIRE1)] =
        deb_c[4'(p * P2_OFFSET + JOY_FIRE1)] & af_phase_d[1'(p)];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      af_phase_q <= 2'b11;
      af_cnt_q   <= '0;
    end else begin
      af_phase_q <= af_phase_d;
      af_cnt_q   <= af_cnt_d;
    end
  end
`else
  always_comb begin
    joy_state_d = deb_c;
  end
`endif

  always_comb begin
    deb_d       = deb_c;
    joy_press_d = press_c;
    any_press_d = |press_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= '1;
      sync2_q     <= '1;
      tick_cnt_q  <= '0;
      deb_q       <= '0;
      joy_state_q <= '0;
      joy_press_q <= '0;
      any_press_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      tick_cnt_q  <= tick_cnt_d;
      deb_q       <= deb_d;
      joy_state_q <= joy_state_d;
      joy_press_q <= joy_press_d;
      any_press_q <= any_press_d;
    end
  end

  assign joy_state = joy_state_q;
  assign joy_press = joy_press_q;
  assign any_press = any_press_q;

endmodule

// File: tb/tb_joy_conditioner.sv
// Directed self-checking bench for joy_conditioner (TICK_DIV=4, DEB_COUNT=3, AF_TICKS=2).
module tb_joy_conditioner;

  logic        clk;
  logic        reset;
  logic [15:0] joy_in;
  logic [15:0] joy_state;
  logic [15:0] joy_press;
  logic        any_press;
`ifdef JOY_AUTOFIRE_EN
  logic [1:0]  af_en;
`endif

  int checks = 0;
  int errors = 0;

  joy_conditioner #(
    .TICK_DIV  (4),
    .DEB_COUNT (3),
    .AF_TICKS  (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef JOY_AUTOFIRE_EN
    .af_en     (af_en),
`endif
    .joy_in    (joy_in),
    .joy_state (joy_state),
    .joy_press (joy_press),
    .any_press (any_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int  n;
    int  pulses;
    int  h;
    int  l;
    bit  seen;
    bit  bad;

    reset  = 1'b1;
    joy_in = 16'hFFFF;
`ifdef JOY_AUTOFIRE_EN
    af_en  = 2'b00;
`endif

    // Reset held 5 cycles: all outputs quiet.
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_state", 32'(joy_state), 32'h0);
      chk("rst_press", 32'(joy_press), 32'h0);
      chk("rst_any",   32'(any_press), 32'h0);
    end
    reset = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("idle_state", 32'(joy_state), 32'h0);

    // Single press of joy1 fire1.
    joy_in[4] = 1'b0;
    n = 0; seen = 0; pulses = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      n++;
      if (joy_press[4]) pulses++;
      if (joy_state[4]) seen = 1;
    end
    chk("fire_rise_seen",    32'(seen), 32'h1);
    chk("fire_latency_ok",   32'(n >= 12 && n <= 16), 32'h1);
    chk("fire_press_coinc",  32'(joy_press), 32'h0010);
    chk("fire_any_coinc",    32'(any_press), 32'h1);
    chk("fire_pulses_before", 32'(pulses), 32'h1);
    step();
    chk("fire_press_1cyc",   32'(joy_press), 32'h0);
    chk("fire_any_1cyc",     32'(any_press), 32'h0);
    chk("fire_state_held",   32'(joy_state), 32'h0010);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (|joy_press) pulses++;
    end
    chk("fire_no_repulse",   32'(pulses), 32'h0);
    chk("fire_still_held",   32'(joy_state), 32'h0010);

    // Release: state clears, no pulse.
    joy_in[4] = 1'b1;
    pulses = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (|joy_press) pulses++;
    end
    chk("rel_state",  32'(joy_state), 32'h0);
    chk("rel_pulses", 32'(pulses), 32'h0);

    // Glitch on joy1 up lasting only 2 ticks.
    joy_in[0] = 1'b0;
    for (int i = 0; i < 8; i++) step();
    joy_in[0] = 1'b1;
    bad = 0; pulses = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (joy_state[0]) bad = 1;
      if (any_press) pulses++;
    end
    chk("glitch_state", 32'(bad), 32'h0);
    chk("glitch_press", 32'(pulses), 32'h0);

    // Simultaneous right on both players.
    joy_in[3]  = 1'b0;
    joy_in[11] = 1'b0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (any_press) seen = 1;
    end
    chk("dual_seen",  32'(seen), 32'h1);
    chk("dual_press", 32'(joy_press), 32'h0808);
    chk("dual_state", 32'(joy_state), 32'h0808);
    joy_in[3]  = 1'b1;
    joy_in[11] = 1'b1;
    for (int i = 0; i < 24; i++) step();
    chk("dual_rel_state", 32'(joy_state), 32'h0);

    // Reset mid-debounce discards the partial count.
    joy_in[7] = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("mid_pre_state", 32'(joy_state), 32'h0);
    reset = 1'b1;
    step();
    chk("mid_rst_state", 32'(joy_state), 32'h0);
    reset = 1'b0;
    n = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      n++;
      if (joy_state[7]) seen = 1;
    end
    chk("mid_rise_seen",   32'(seen), 32'h1);
    chk("mid_rise_timing", 32'(n >= 12 && n <= 14), 32'h1);
    chk("mid_press",       32'(joy_press), 32'h0080);
    joy_in[7] = 1'b1;
    for (int i = 0; i < 24; i++) step();
    chk("mid_rel_state", 32'(joy_state), 32'h0);

`ifdef JOY_AUTOFIRE_EN
    // Autofire on player 1 fire1.
    af_en = 2'b01;
    joy_in[4] = 1'b0;
    seen = 0; pulses = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (joy_press[4]) pulses++;
      if (joy_state[4]) seen = 1;
    end
    chk("af_rise_seen", 32'(seen), 32'h1);
    h = 0;
    while (joy_state[4] && h < 30) begin
      step();
      h++;
      if (joy_press[4]) pulses++;
    end
    chk("af_first_high", 32'(h >= 6 && h <= 8), 32'h1);
    l = 0;
    while (!joy_state[4] && l < 30) begin
      step();
      l++;
      if (joy_press[4]) pulses++;
    end
    chk("af_low_len",    32'(l), 32'd8);
    chk("af_third_high", 32'(joy_state[4]), 32'h1);
    chk("af_one_press",  32'(pulses), 32'h1);
    joy_in[4] = 1'b1;
    for (int i = 0; i < 24; i++) step();
    chk("af_rel_state", 32'(joy_state), 32'h0);
    af_en = 2'b00;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/joy_conditioner.md
JOY_CONDITIONER -- requirements
Module: joy_conditioner

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1024: clk cycles per debounce sample tick (legal range 2..65535).
REQ-002 SHALL have parameter DEB_COUNT, default 4: number of consecutive differing ticks required to accept a change (legal range 1..15).
REQ-003 SHALL have parameter AF_TICKS, default 8: ticks per autofire half-period (legal range 1..255).
REQ-004 SHALL have port clk, input, 1 bit: single clock; every register in the block is clocked on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port joy_in, input, 16 bits: raw active-low buttons, asynchronous to clk. Bits [7:0] are joy1 up, down, left, right, fire1, fire2, fire3, start; bits [15:8] are joy2 in the same order.
REQ-007 SHALL have port joy_state, output, 16 bits: debounced buttons, active-high (1 = pressed), same bit order as joy_in.
REQ-008 SHALL have port joy_press, output, 16 bits: one-cycle pulse per bit when that bit of joy_state goes 0->1.
REQ-009 SHALL have port any_press, output, 1 bit: OR-reduction of joy_press, registered in the same cycle as joy_press.

Function
REQ-010 SHALL pass joy_in through a two-flop synchronizer per bit before any other use.
REQ-011 SHALL run a tick counter 0..TICK_DIV-1 that wraps to 0, and assert an internal tick for the single cycle in which the counter equals TICK_DIV-1.
REQ-012 SHALL keep, per bit, a stable level and a counter DEB_W = clog2(DEB_COUNT+1) bits wide.
REQ-013 SHALL, on each tick for each bit: if the synced level equals the stable level, clear the counter; otherwise, if counter = DEB_COUNT-1, invert the stable level and clear the counter; otherwise increment the counter.
REQ-014 SHALL leave stable levels and counters unchanged on non-tick cycles.
REQ-015 SHALL register joy_state = ~stable, so joy_state changes in the cycle after the accepting tick.
REQ-016 SHALL assert joy_press[n] for exactly one cycle, coincident with the cycle in which joy_state[n] first reads 1; releases produce no pulse.
REQ-017 SHALL latch a new level only after DEB_COUNT consecutive ticks of difference; a glitch shorter than that leaves joy_state unchanged.
REQ-018 SHALL handle simultaneous changes on multiple bits independently within the same tick.

Reset
REQ-019 SHALL, while reset=1, set synchronizer flops and stable levels to 1 (released), all counters including the tick counter to 0, joy_state and joy_press to 0, and any_press to 0.
REQ-020 SHALL, when reset is asserted mid-debounce, discard the partial count, and restart counting from the first tick after reset deasserts.

Configuration
REQ-021 SHALL, with macro JOY_AUTOFIRE_EN defined, add input port af_en, 2 bits (bit0 = joy1, bit1 = joy2). While af_en[p]=1 and fire1 of player p is debounced-pressed, joy_state fire1 for that player SHALL toggle every AF_TICKS ticks, starting at 1 on the press and returning to 0 when the button is released.
REQ-022 SHALL, with JOY_AUTOFIRE_EN undefined, omit af_en and all autofire logic; fire1 then behaves like every other bit.
REQ-023 SHALL NOT let autofire toggles generate joy_press pulses beyond the initial press.

Structure
REQ-024 SHALL place the bit-index constants (JOY_UP..JOY_START, P2_OFFSET = 8) in shared package joy_pkg.
REQ-025 SHALL implement the per-bit counter and stable level in sub-module joy_debounce_bit, instantiated 16 times.

Verification (all with TICK_DIV=4, DEB_COUNT=3, AF_TICKS=2)
REQ-026 SHALL check: reset held 5 cycles, joy_in = 16'hFFFF -> joy_state = 0, joy_press = 0, any_press = 0 throughout.
REQ-027 SHALL check: joy_in[4] driven low and held -> joy_state[4] rises after 3 ticks (12-16 cycles after input); joy_press[4] and any_press high for exactly 1 cycle.
REQ-028 SHALL check: joy_in[0] low for 2 ticks then high -> joy_state[0] stays 0 and no pulse is produced.
REQ-029 SHALL check: joy_in[3] and joy_in[11] go low on the same cycle -> both joy_state bits rise in the same cycle and joy_press = 16'h0808.
REQ-030 SHALL check: reset pulsed after 2 ticks of a low joy_in[7] -> after reset, joy_state[7] rises only 3 full ticks later.
REQ-031 SHALL check, with JOY_AUTOFIRE_EN defined and af_en = 2'b01: joy1 fire1 held -> joy_state[4] toggles 1,0,1 every 2 ticks; joy_press[4] pulses only once.
